spram_arbiter: RTL and testbench

- Two-requester round-robin arbiter sharing one single-ported 32K x 8 SPRAM (spram_32k interface) between independent byte-access clients, e.g. a UART/FIFO writer and a frame/packet reader.
- Grants at most one access per clock and drives the RAM-side cs/wren/addr/write_data.
- Returns read data to the owning port with fixed latency.
- Sits between client logic and the spram_32k instance.

---
 rtl/spram_arbiter.sv | 139 +++++++++++++
 tb/tb_spram_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_arbiter.sv
// -----------------------------------------------------------------------------
// spram_arbiter
//
// Two-client round-robin arbiter in front of a single-ported 32K x 8 SPRAM.
// At most one access is granted per clock. The granted port's request is
// steered onto the RAM-side bus in the same cycle. Read data comes back to the
// owning port two cycles after its ack.
//
// Ports:
//   clk        system clock, all logic on posedge
//   reset      asynchronous, active-low reset
//   a_req/b_req        request, held by the client until its ack
//   a_we/b_we          1 = write, 0 = read
//   a_addr/b_addr      byte address
//   a_wdata/b_wdata    write data
//   a_ack/b_ack        request accepted this cycle (combinational)
//   a_rdata/b_rdata    registered read data, held until the port's next read
//   a_rvalid/b_rvalid  one-cycle pulse when rdata has just been updated
//   ram_cs/ram_wren/ram_addr/ram_wdata  RAM-side command bus
//   ram_rdata          RAM read data, valid the cycle after a read access
// -----------------------------------------------------------------------------
module spram_arbiter #(
    parameter int ADDR_BITS = 15,
    parameter int WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [ADDR_BITS-1:0] a_addr,
    input  logic [WIDTH-1:0]     a_wdata,
    output logic                 a_ack,
    output logic [WIDTH-1:0]     a_rdata,
    output logic                 a_rvalid,

    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [ADDR_BITS-1:0] b_addr,
    input  logic [WIDTH-1:0]     b_wdata,
    output logic                 b_ack,
    output logic [WIDTH-1:0]     b_rdata,
    output logic                 b_rvalid,

    output logic                 ram_cs,
    output logic                 ram_wren,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [WIDTH-1:0]     ram_wdata,
    input  logic [WIDTH-1:0]     ram_rdata
);

    // Priority: 0 = port A wins a tie, 1 = port B wins a tie.
    logic prio_q, prio_d;

    // Read pipeline. Stage 1 marks the cycle in which ram_rdata is valid;
    // stage 2 marks the cycle in which the port's rdata register is fresh.
    // The *_port flags hold the owner: 0 = A, 1 = B.
    logic rd1_vld_q, rd1_vld_d, rd1_port_q, rd1_port_d;
    logic rd2_vld_q, rd2_port_q;

    logic [WIDTH-1:0] a_rdata_q, b_rdata_q;

    logic grant_a, grant_b;

    // Arbitration and RAM command mux. Grants are gated by reset so that no
    // access reaches the RAM while reset is held, even with requests pending.
    always_comb begin
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        ram_cs    = 1'b0;
        ram_wren  = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        prio_d    = prio_q;
        rd1_vld_d = 1'b0;
        rd1_port_d = 1'b0;

        if (reset) begin
            if (a_req && (!b_req || !prio_q)) begin
                grant_a = 1'b1;
            end else if (b_req) begin
                grant_b = 1'b1;
            end
        end

        if (grant_a) begin
            ram_cs    = 1'b1;
            ram_wren  = a_we;
            ram_addr  = a_addr;
            ram_wdata = a_wdata;
            prio_d    = 1'b1;
            rd1_vld_d = !a_we;
            rd1_port_d = 1'b0;
        end else if (grant_b) begin
            ram_cs    = 1'b1;
            ram_wren  = b_we;
            ram_addr  = b_addr;
            ram_wdata = b_wdata;
            prio_d    = 1'b0;
            rd1_vld_d = !b_we;
            rd1_port_d = 1'b1;
        end
    end

    assign a_ack = grant_a;
    assign b_ack = grant_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_q     <= 1'b0;
            rd1_vld_q  <= 1'b0;
            rd1_port_q <= 1'b0;
            rd2_vld_q  <= 1'b0;
            rd2_port_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            prio_q     <= prio_d;
            rd1_vld_q  <= rd1_vld_d;
            rd1_port_q <= rd1_port_d;
            rd2_vld_q  <= rd1_vld_q;
            rd2_port_q <= rd1_port_q;
            // Only the owning port's data register moves; the other holds.
            if (rd1_vld_q) begin
                if (rd1_port_q) begin
                    b_rdata_q <= ram_rdata;
                end else begin
                    a_rdata_q <= ram_rdata;
                end
            end
        end
    end

    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;
    assign a_rvalid = rd2_vld_q && !rd2_port_q;
    assign b_rvalid = rd2_vld_q &&  rd2_port_q;

endmodule

// File: tb/tb_spram_arbiter.sv
module tb_spram_arbiter;

    localparam int ADDR_BITS = 15;
    localparam int WIDTH     = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 a_req, a_we, b_req, b_we;
    logic [ADDR_BITS-1:0] a_addr, b_addr;
    logic [WIDTH-1:0]     a_wdata, b_wdata;
    logic                 a_ack, b_ack, a_rvalid, b_rvalid;
    logic [WIDTH-1:0]     a_rdata, b_rdata;
    logic                 ram_cs, ram_wren;
    logic [ADDR_BITS-1:0] ram_addr;
    logic [WIDTH-1:0]     ram_wdata;
    logic [WIDTH-1:0]     ram_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spram_arbiter #(.ADDR_BITS(ADDR_BITS), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .ram_cs(ram_cs), .ram_wren(ram_wren), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // SPRAM model: registered read, write on the edge, contents preset to
    // addr[7:0] ^ 0x5A so that unwritten locations have known values.
    logic [WIDTH-1:0] mem [0:(1<<ADDR_BITS)-1];
    initial begin
        for (int i = 0; i < (1 << ADDR_BITS); i++) begin
            mem[i] = WIDTH'(i) ^ 8'h5A;
        end
        ram_rdata = '0;
    end
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_wren) mem[ram_addr] <= ram_wdata;
            else          ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;

        // ---------------- reset, then idle ----------------
        a_req = 1; b_req = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_a_ack", a_ack, 0);
        check_eq("rst_b_ack", b_ack, 0);
        check_eq("rst_ram_cs", ram_cs, 0);
        check_eq("rst_rdata", {a_rdata, b_rdata}, 0);
        check_eq("rst_rvalid", {a_rvalid, b_rvalid}, 0);
        tick();
        idle_inputs();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("idle_outputs",
                     {a_ack, b_ack, ram_cs, ram_wren, a_rvalid, b_rvalid,
                      a_rdata, b_rdata, ram_addr, ram_wdata}, 0);
            tick();
        end
        $display("idle: 10 cycles checked after reset");

        // ---------------- port A write then read ----------------
        a_req = 1; a_we = 1; a_addr = 15'h0001; a_wdata = 8'hA5;
        @(negedge clk);
        check_eq("w1_a_ack", a_ack, 1);
        check_eq("w1_b_ack", b_ack, 0);
        check_eq("w1_cs_wren", {ram_cs, ram_wren}, 2'b11);
        check_eq("w1_addr", ram_addr, 15'h0001);
        check_eq("w1_wdata", ram_wdata, 8'hA5);
        $display("A write 0x0001 <= 0xa5");
        tick();
        a_we = 0;
        @(negedge clk);
        check_eq("r1_a_ack", a_ack, 1);
        check_eq("r1_wren", ram_wren, 0);
        check_eq("r1_addr", ram_addr, 15'h0001);
        tick();
        a_req = 0;
        @(negedge clk);
        check_eq("r1_rvalid_t1", a_rvalid, 0);
        check_eq("r1_cs_idle", ram_cs, 0);
        tick();
        @(negedge clk);
        check_eq("r1_rvalid_t2", a_rvalid, 1);
        check_eq("r1_rdata", a_rdata, 8'hA5);
        check_eq("r1_b_rvalid", b_rvalid, 0);
        $display("A read 0x0001 -> 0x%0h", a_rdata);
        tick();
        @(negedge clk);
        check_eq("r1_rvalid_off", a_rvalid, 0);
        check_eq("r1_rdata_hold", a_rdata, 8'hA5);
        tick();

        // ---------------- port B read of same address ----------------
        b_req = 1; b_we = 0; b_addr = 15'h0001;
        @(negedge clk);
        check_eq("rb_b_ack", b_ack, 1);
        tick();
        b_req = 0;
        tick();
        @(negedge clk);
        check_eq("rb_b_rvalid", b_rvalid, 1);
        check_eq("rb_b_rdata", b_rdata, 8'hA5);
        check_eq("rb_a_rvalid", a_rvalid, 0);
        check_eq("rb_a_rdata_hold", a_rdata, 8'hA5);
        $display("B read 0x0001 -> 0x%0h", b_rdata);
        tick();

        // ---------------- both ports contending ----------------
        begin
            int ia = 0;
            int ib = 0;
            for (int k = 0; k < 10; k++) begin
                a_req = (ia < 4); a_we = 0; a_addr = 15'(16 + ia);
                b_req = (ib < 4); b_we = 1; b_addr = 15'(256 + ib);
                b_wdata = 8'(8'hB0 + ib);
                @(negedge clk);
                if (k < 8) begin
                    check_eq("rr_a_ack", a_ack, (k % 2) == 0);
                    check_eq("rr_b_ack", b_ack, (k % 2) == 1);
                    if ((k % 2) == 1) begin
                        check_eq("rr_b_wdata", ram_wdata, 8'(8'hB0 + ib));
                        check_eq("rr_b_addr", ram_addr, 15'(256 + ib));
                    end
                end
                if (k >= 2 && ((k - 2) % 2) == 0) begin
                    check_eq("rr_a_rvalid", a_rvalid, 1);
                    check_eq("rr_a_rdata", a_rdata, 8'(16 + (k - 2) / 2) ^ 8'h5A);
                    $display("A read 0x%04h -> 0x%0h", 16 + (k - 2) / 2, a_rdata);
                end else begin
                    check_eq("rr_a_rvalid_off", a_rvalid, 0);
                end
                check_eq("rr_b_rvalid", b_rvalid, 0);
                if (k < 8) begin
                    if ((k % 2) == 0) ia++;
                    else begin
                        $display("B write 0x%04h <= 0x%0h", 256 + ib, 8'hB0 + ib);
                        ib++;
                    end
                end
                tick();
            end
        end
        idle_inputs();

        // ---------------- adjacent byte lanes ----------------
        a_req = 1; a_we = 1; a_addr = 15'h0002; a_wdata = 8'h11;
        @(negedge clk); check_eq("ln_w2_ack", a_ack, 1); tick();
        a_addr = 15'h0003; a_wdata = 8'h22;
        @(negedge clk); check_eq("ln_w3_ack", a_ack, 1); tick();
        a_we = 0; a_addr = 15'h0002;
        @(negedge clk); check_eq("ln_r2_ack", a_ack, 1); tick();
        a_addr = 15'h0003;
        @(negedge clk);
        check_eq("ln_r3_ack", a_ack, 1);
        check_eq("ln_rvalid_early", a_rvalid, 0);
        tick();
        a_req = 0;
        @(negedge clk);
        check_eq("ln_rv2", a_rvalid, 1);
        check_eq("ln_rd2", a_rdata, 8'h11);
        $display("A read 0x0002 -> 0x%0h", a_rdata);
        tick();
        @(negedge clk);
        check_eq("ln_rv3", a_rvalid, 1);
        check_eq("ln_rd3", a_rdata, 8'h22);
        $display("A read 0x0003 -> 0x%0h", a_rdata);
        tick();
        @(negedge clk);
        check_eq("ln_rv_off", a_rvalid, 0);
        tick();

        // ---------------- cross-port read-after-write ----------------
        a_req = 1; a_we = 0; a_addr = 15'h7FFF;
        b_req = 1; b_we = 1; b_addr = 15'h7FFF; b_wdata = 8'h3C;
        @(negedge clk);
        check_eq("raw_b_ack", b_ack, 1);
        check_eq("raw_a_ack0", a_ack, 0);
        check_eq("raw_wren", ram_wren, 1);
        check_eq("raw_addr", ram_addr, 15'h7FFF);
        tick();
        b_req = 0; b_we = 0;
        @(negedge clk);
        check_eq("raw_a_ack", a_ack, 1);
        check_eq("raw_b_ack0", b_ack, 0);
        tick();
        a_req = 0;
        @(negedge clk); check_eq("raw_rv_early", a_rvalid, 0); tick();
        @(negedge clk);
        check_eq("raw_rvalid", a_rvalid, 1);
        check_eq("raw_rdata", a_rdata, 8'h3C);
        $display("B write 0x7fff <= 0x3c, A read 0x7fff -> 0x%0h", a_rdata);
        tick();

        // ---------------- reset with a read in flight ----------------
        a_req = 1; a_we = 0; a_addr = 15'h0002;
        @(negedge clk); check_eq("rip_a_ack", a_ack, 1); tick();
        reset = 1'b0;
        a_req = 1; b_req = 1;
        @(negedge clk);
        check_eq("rip_rdata_clr", {a_rdata, b_rdata}, 0);
        check_eq("rip_rvalid", {a_rvalid, b_rvalid}, 0);
        check_eq("rip_acks", {a_ack, b_ack, ram_cs}, 0);
        tick();
        @(negedge clk);
        check_eq("rip_rvalid2", {a_rvalid, b_rvalid}, 0);
        tick();
        reset = 1'b1;
        a_addr = 15'h0003; b_we = 0; b_addr = 15'h0002;
        @(negedge clk);
        check_eq("post_a_ack", a_ack, 1);
        check_eq("post_b_ack", b_ack, 0);
        check_eq("post_rvalid", {a_rvalid, b_rvalid}, 0);
        tick();
        a_req = 0;
        @(negedge clk);
        check_eq("post_b_ack2", b_ack, 1);
        check_eq("post_rvalid2", {a_rvalid, b_rvalid}, 0);
        check_eq("post_a_rdata", a_rdata, 0);
        tick();
        b_req = 0;
        @(negedge clk);
        check_eq("post_a_rvalid", a_rvalid, 1);
        check_eq("post_a_rd", a_rdata, 8'h22);
        $display("post-reset A read 0x0003 -> 0x%0h", a_rdata);
        tick();
        @(negedge clk);
        check_eq("post_b_rvalid", {a_rvalid, b_rvalid}, 2'b01);
        check_eq("post_b_rd", b_rdata, 8'h11);
        $display("post-reset B read 0x0002 -> 0x%0h", b_rdata);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
